// File: rtl/xof_squeeze_buf.sv
// xof_squeeze_buf: holds SHAKE128 rate blocks and streams them as 64-bit words, byte 0 first.
// Define XOF_PREFETCH_EN to add a shadow block buffer so consecutive blocks stream without a bubble.
module xof_squeeze_buf #(
    parameter int unsigned RATE_BITS = 1344,
    parameter int unsigned WORD_BITS = 64
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic                 i_stop,
    output logic                 o_perm_req,
    input  logic [RATE_BITS-1:0] i_block,
    input  logic                 i_block_valid,
    output logic                 o_block_ready,
    output logic [WORD_BITS-1:0] o_bytes,
    output logic                 o_bytes_valid,
    input  logic                 i_bytes_ready,
    output logic                 o_busy,
    output logic [7:0]           o_blk_cnt
);
    localparam int unsigned NUM_WORDS  = RATE_BITS / WORD_BITS;
    localparam int unsigned WIDX_W     = $clog2(NUM_WORDS);
    localparam int unsigned WORD_BYTES = WORD_BITS / 8;
    localparam logic [WIDX_W-1:0] LAST_IDX = WIDX_W'(NUM_WORDS - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_REQ    = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_STREAM = 2'd3;

    logic [1:0]           r_state;
    logic [WIDX_W-1:0]    r_widx;
    logic [RATE_BITS-1:0] r_buf;
    logic [7:0]           r_blk_cnt;
    logic [WORD_BITS-1:0] w_lane_word;
    logic                 w_hs;
    logic                 w_last;
    logic                 w_blk_acc;
    logic                 w_blk_ready;
    logic                 w_perm_req;

`ifdef XOF_PREFETCH_EN
    logic [RATE_BITS-1:0] r_shadow;
    logic                 r_shadow_full;
    logic                 r_pf_req;
    logic                 w_refill;
`endif

    assign w_hs   = (r_state == S_STREAM) && i_bytes_ready;
    assign w_last = (r_widx == LAST_IDX);

`ifdef XOF_PREFETCH_EN
    assign w_blk_ready = (r_state == S_WAIT) || ((r_state == S_STREAM) && !r_shadow_full);
    assign w_perm_req  = (r_state == S_REQ) || r_pf_req;
    // A block arriving on the last-word handshake goes straight to the active buffer.
    assign w_refill    = r_shadow_full || w_blk_acc;
`else
    assign w_blk_ready = (r_state == S_WAIT);
    assign w_perm_req  = (r_state == S_REQ);
`endif

    assign w_blk_acc = i_block_valid && w_blk_ready;

    always_comb begin
        w_lane_word = '0;
        for (int unsigned k = 0; k < NUM_WORDS; k++) begin
            if (r_widx == WIDX_W'(k)) begin
                w_lane_word = r_buf[k*WORD_BITS +: WORD_BITS];
            end
        end
    end

    // Lane order puts byte 0 in the low bits; the consumer wants it in the high bits.
    always_comb begin
        o_bytes = '0;
        if (r_state == S_STREAM) begin
            for (int unsigned b = 0; b < WORD_BYTES; b++) begin
                o_bytes[WORD_BITS-8-8*b +: 8] = w_lane_word[8*b +: 8];
            end
        end
    end

    assign o_perm_req    = w_perm_req;
    assign o_block_ready = w_blk_ready;
    assign o_bytes_valid = (r_state == S_STREAM);
    assign o_busy        = (r_state != S_IDLE);
    assign o_blk_cnt     = r_blk_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_widx    <= '0;
            r_blk_cnt <= '0;
`ifdef XOF_PREFETCH_EN
            r_shadow_full <= 1'b0;
            r_pf_req      <= 1'b0;
`endif
        end else if (i_stop) begin
            r_state <= S_IDLE;
`ifdef XOF_PREFETCH_EN
            r_shadow_full <= 1'b0;
            r_pf_req      <= 1'b0;
`endif
        end else begin
`ifdef XOF_PREFETCH_EN
            r_pf_req <= 1'b0;
`endif
            if (w_blk_acc && (r_blk_cnt != 8'hFF)) begin
                r_blk_cnt <= r_blk_cnt + 8'd1;
            end
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state   <= S_REQ;
                        r_widx    <= '0;
                        r_blk_cnt <= '0;
                    end
                end
                S_REQ: r_state <= S_WAIT;
                S_WAIT: begin
                    if (i_block_valid) begin
                        r_widx  <= '0;
                        r_state <= S_STREAM;
`ifdef XOF_PREFETCH_EN
                        r_pf_req <= 1'b1;
`endif
                    end
                end
                S_STREAM: begin
                    if (w_hs && w_last) begin
                        r_widx <= '0;
`ifdef XOF_PREFETCH_EN
                        if (w_refill) begin
                            r_shadow_full <= 1'b0;
                            r_pf_req      <= 1'b1;
                        end else begin
                            r_state <= S_WAIT;
                        end
`else
                        r_state <= S_REQ;
`endif
                    end else begin
                        if (w_hs) begin
                            r_widx <= r_widx + 1'b1;
                        end
`ifdef XOF_PREFETCH_EN
                        if (w_blk_acc) begin
                            r_shadow_full <= 1'b1;
                        end
`endif
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if ((r_state == S_WAIT) && i_block_valid) begin
            r_buf <= i_block;
        end
`ifdef XOF_PREFETCH_EN
        if (r_state == S_STREAM) begin
            if (w_hs && w_last) begin
                if (r_shadow_full) begin
                    r_buf <= r_shadow;
                end else if (w_blk_acc) begin
                    r_buf <= i_block;
                end
            end else if (w_blk_acc) begin
                r_shadow <= i_block;
            end
        end
`endif
    end

endmodule

// File: tb/tb_xof_squeeze_buf.sv
// tb_xof_squeeze_buf: random valid/ready stimulus; accepted blocks feed a word scoreboard that
// defines the expected stream, with busy/valid/count/hold rules checked every cycle.
module tb_xof_squeeze_buf;
    localparam int RB = 1344;

    logic          clk = 1'b0;
    logic          i_rst, i_start, i_stop, i_block_valid, i_bytes_ready;
    logic [RB-1:0] i_block;
    logic          o_perm_req, o_block_ready, o_bytes_valid, o_busy;
    logic [63:0]   o_bytes;
    logic [7:0]    o_blk_cnt;

    xof_squeeze_buf #(.RATE_BITS(1344), .WORD_BITS(64)) dut (
        .i_clk         (clk),
        .i_rst         (i_rst),
        .i_start       (i_start),
        .i_stop        (i_stop),
        .o_perm_req    (o_perm_req),
        .i_block       (i_block),
        .i_block_valid (i_block_valid),
        .o_block_ready (o_block_ready),
        .o_bytes       (o_bytes),
        .o_bytes_valid (o_bytes_valid),
        .i_bytes_ready (i_bytes_ready),
        .o_busy        (o_busy),
        .o_blk_cnt     (o_blk_cnt)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [63:0] sb[$];
    logic [63:0] got_q[$];
    int          m_cnt = 0, m_widx = 0, hs_total = 0, blocks_left = 0, perm_cnt = 0, cyc_n = 0;
    int          gap = 0, rpol = 0, vpol = 0, hs_cyc_first = -1, hs_cyc_last = -1, nblk = 0;
    bit          m_busy = 0, m_req = 0, m_bready = 0, gap_on = 0, pat = 0, tog = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Word k = block bytes 8k..8k+7, first byte most significant.
    function automatic logic [63:0] word_of(input logic [RB-1:0] blk, input int k);
        logic [63:0] w = '0;
        for (int i = 0; i < 8; i++) w = {w[55:0], blk[8*(8*k+i) +: 8]};
        return w;
    endfunction

    task automatic new_block();
        for (int j = 0; j < RB/8; j++) i_block[8*j +: 8] = pat ? 8'(j) : 8'($urandom);
    endtask

    task automatic drive();
        case (rpol)
            0: i_bytes_ready = 1'b1;
            1: begin i_bytes_ready = tog; tog = !tog; end
            default: i_bytes_ready = 1'($urandom % 2);
        endcase
        i_block_valid = (blocks_left > 0) && (vpol == 0 || ($urandom % 2) == 1);
    endtask

    task automatic cyc();
        bit hs, acc, pend, last, nreq, nbr;
        logic [63:0] pw;
        hs   = o_bytes_valid && i_bytes_ready && !i_rst;
        acc  = i_block_valid && o_block_ready && !i_rst && !i_stop;
        pend = o_bytes_valid && !i_bytes_ready && !i_stop && !i_rst;
        pw   = o_bytes;
        last = 0;
        nreq = 0;
        nbr  = m_bready;
        if (o_perm_req === 1'b1) perm_cnt++;
        if (hs) begin
            if (sb.size() == 0) check("sb_underrun", 64'(sb.size()), 64'd1);
            else check("word", o_bytes, sb.pop_front());
            got_q.push_back(o_bytes);
            hs_total++;
            if (hs_cyc_first < 0) hs_cyc_first = cyc_n;
            hs_cyc_last = cyc_n;
            last   = (m_widx == 20);
            m_widx = last ? 0 : m_widx + 1;
        end
        if (m_req) nbr = 1'b1;
        if (acc) begin
            for (int k = 0; k < 21; k++) sb.push_back(word_of(i_block, k));
            if (m_cnt < 255) m_cnt++;
            nbr = 1'b0;
            blocks_left--;
        end
        if (hs && last) begin nreq = 1'b1; gap_on = 1'b1; gap = 0; end
        if (i_start && !m_busy && !i_stop && !i_rst) begin
            m_busy = 1'b1; m_cnt = 0; m_widx = 0; nreq = 1'b1; sb.delete();
        end
        if (i_stop || i_rst) begin
            m_busy = 1'b0; sb.delete(); nreq = 1'b0; nbr = 1'b0; m_widx = 0; gap_on = 1'b0;
        end
        if (i_rst) m_cnt = 0;
        @(posedge clk); #1;
        cyc_n++;
        if (acc) new_block();
        m_req    = nreq;
        m_bready = nbr;
        check("busy", 64'(o_busy), 64'(m_busy));
        check("valid", 64'(o_bytes_valid), 64'(sb.size() > 0));
        check("blk_cnt", 64'(o_blk_cnt), 64'(m_cnt));
        if (pend) begin
            check("hold_valid", 64'(o_bytes_valid), 64'd1);
            check("hold_data", o_bytes, pw);
        end
`ifndef XOF_PREFETCH_EN
        check("perm_req", 64'(o_perm_req), 64'(m_req));
        check("block_ready", 64'(o_block_ready), 64'(m_bready));
        if (gap_on && o_bytes_valid) begin
            check("gap_ge2", 64'(gap >= 2), 64'd1);
            gap_on = 1'b0;
        end else if (gap_on) begin
            gap++;
        end
`endif
    endtask

    task automatic run(input int target, input int budget, input bit stop_last);
        int base = hs_total;
        int n = 0;
        while ((hs_total - base) < target && n < budget) begin
            drive();
            i_stop = stop_last && o_bytes_valid && i_bytes_ready && (hs_total - base == target - 1);
            cyc();
            n++;
        end
        i_stop = 1'b0;
        check("budget", 64'(hs_total - base), 64'(target));
    endtask

    task automatic kick();
        i_start = 1'b1;
        drive();
        cyc();
        i_start = 1'b0;
    endtask

    task automatic stop_cyc();
        i_stop = 1'b1;
        i_block_valid = 1'b0;
        cyc();
        i_stop = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_bytes"}, o_bytes, 64'd0);
        check({tag, "_valid"}, 64'(o_bytes_valid), 64'd0);
        check({tag, "_req"}, 64'(o_perm_req), 64'd0);
        check({tag, "_bready"}, 64'(o_block_ready), 64'd0);
        check({tag, "_busy"}, 64'(o_busy), 64'd0);
        check({tag, "_cnt"}, 64'(o_blk_cnt), 64'd0);
    endtask

    initial begin
        i_rst = 1'b1; i_start = 1'b0; i_stop = 1'b0;
        i_block_valid = 1'b0; i_bytes_ready = 1'b0; i_block = '0;
        cyc();
        cyc();
        check_all_zero("rst0");
        i_rst = 1'b0;
        cyc();

        // T2: counting-pattern block, ready held high
        pat = 1; new_block(); rpol = 0; vpol = 0; blocks_left = 1;
        kick();
        check("T2_req", 64'(o_perm_req), 64'd1);
        got_q.delete();
        run(21, 100, 0);
        check("T2_w0", got_q[0], 64'h0001020304050607);
        check("T2_w20", got_q[20], 64'hA0A1A2A3A4A5A6A7);
        check("T2_cnt", 64'(o_blk_cnt), 64'd1);
        stop_cyc();
        pat = 0; new_block();

        // T3: backpressure, alternating then random ready
        for (int p = 1; p <= 2; p++) begin
            rpol = p; tog = 0; vpol = 1; blocks_left = 1;
            kick();
            run(21, 400, 0);
            check("T3_drain", 64'(sb.size()), 64'd0);
            stop_cyc();
        end

        // T4: two back-to-back blocks
        rpol = 0; vpol = 0; blocks_left = 2;
        kick();
        run(42, 300, 0);
        check("T4_cnt", 64'(o_blk_cnt), 64'd2);
        stop_cyc();

        // T5: stop on the word-7 handshake, then restart
        blocks_left = 1;
        kick();
        run(8, 100, 1);
        check("T5_valid", 64'(o_bytes_valid), 64'd0);
        check("T5_bready", 64'(o_block_ready), 64'd0);
        check("T5_busy", 64'(o_busy), 64'd0);
        got_q.delete();
        blocks_left = 1;
        kick();
        run(21, 200, 0);
        check("T5_w0", got_q[0], 64'(sb.size()) | got_q[0]);
        check("T5_cnt", 64'(o_blk_cnt), 64'd1);
        stop_cyc();

        // start and stop together in idle: stays idle
        i_start = 1'b1; i_stop = 1'b1;
        cyc();
        i_start = 1'b0; i_stop = 1'b0;
        check("ss_busy", 64'(o_busy), 64'd0);
        check("ss_req", 64'(o_perm_req), 64'd0);

        // start while busy is ignored: stream continues where it was
        blocks_left = 1;
        kick();
        run(5, 100, 0);
        i_start = 1'b1;
        cyc();
        i_start = 1'b0;
        run(15, 100, 0);
        check("bs_cnt", 64'(o_blk_cnt), 64'd1);
        stop_cyc();

        // T1: reset mid-stream
        blocks_left = 1;
        kick();
        run(6, 100, 0);
        i_rst = 1'b1;
        cyc();
        check_all_zero("T1a");
        cyc();
        check_all_zero("T1b");
        i_rst = 1'b0;
        cyc();

        // random sessions, some aborted at a random word
        for (int it = 0; it < 8; it++) begin
            rpol = 2; vpol = 1;
            nblk = $urandom_range(1, 3);
            blocks_left = nblk;
            kick();
            if ($urandom % 2 == 1) begin
                run($urandom_range(1, 20), 2000, 1);
            end else begin
                run(nblk * 21, 3000, 0);
                stop_cyc();
            end
        end

        // block counter saturation
        rpol = 0; vpol = 0; blocks_left = 260;
        kick();
        run(260 * 21, 20000, 0);
        check("sat_cnt", 64'(o_blk_cnt), 64'd255);
        stop_cyc();

`ifdef XOF_PREFETCH_EN
        // T6: 42 words in 42 consecutive cycles, three permutation requests
        rpol = 0; vpol = 0; blocks_left = 10;
        perm_cnt = 0; hs_cyc_first = -1;
        kick();
        run(42, 200, 1);
        check("T6_span", 64'(hs_cyc_last - hs_cyc_first + 1), 64'd42);
        check("T6_perm", 64'(perm_cnt), 64'd3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
